// File: rtl/eth_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of the MAC transmit port: latches one source's buffer,
// runs the level send/done handshake with timeout, then enforces an idle gap.
//
// state     | meaning
// S_IDLE    | waiting for a request while the synchronised done is low
// S_SEND    | tx_send_o high, waiting for done from the MAC
// S_RELEASE | done seen, waiting for the MAC to drop it
// S_GAP     | grant dropped, counting the inter-packet gap
module eth_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int GAP_CYC     = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [16*NREQ-1:0]   req_len_i,
    input  logic [16*NREQ-1:0]   req_addr_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic                 busy_o,
    output logic                 tx_send_o,
    output logic [15:0]          tx_len_o,
    output logic [15:0]          tx_addr_o,
    input  logic                 tx_done_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_q, last_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       addr_q, addr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              send_q, send_d;
    logic              busy_q, busy_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              done_meta_q, done_s_q;

    logic [15:0]       len_arr  [NREQ];
    logic [15:0]       addr_arr [NREQ];
    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [NREQ-1:0]   sel_oh;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign len_arr[g]  = req_len_i[16*g +: 16];
        assign addr_arr[g] = req_addr_i[16*g +: 16];
    end

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NREQ;
        return IW'(s);
    endfunction

    // Search upward from the source after the last one served, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!sel_found && req_i[wrap_idx(last_q, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(last_q, i);
            end
        end
    end

    assign sel_oh = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
        end else begin
            done_meta_q <= tx_done_i;
            done_s_q    <= done_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        len_d   = len_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        send_d  = send_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;

        unique case (state_q)
            S_IDLE: begin
                // A done still high from the previous packet would complete
                // the next one instantly, so selection waits for it to clear.
                if (sel_found && !done_s_q) begin
                    idx_d  = sel_idx;
                    len_d  = len_arr[sel_idx];
                    addr_d = addr_arr[sel_idx];
                    if (len_arr[sel_idx] == 16'd0) begin
                        done_d  = sel_oh;
                        last_d  = sel_idx;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        grant_d = sel_oh;
                        send_d  = 1'b1;
                        tmr_d   = TMR_LOAD;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (done_s_q) begin
                    send_d  = 1'b0;
                    done_d  = grant_q;
                    tmr_d   = TMR_LOAD;
                    state_d = S_RELEASE;
                end else if (tmr_q == '0) begin
                    send_d  = 1'b0;
                    err_d   = grant_q;
                    grant_d = '0;
                    last_d  = idx_q;
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_RELEASE: begin
                if (!done_s_q || tmr_q == '0) begin
                    err_d   = done_s_q ? grant_q : '0;
                    grant_d = '0;
                    last_d  = idx_q;
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_GAP: begin
                grant_d = '0;
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            len_q   <= '0;
            addr_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            tmr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
        end
    end

    assign grant_o   = grant_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign tx_send_o = send_q;
    assign tx_len_o  = len_q;
    assign tx_addr_o = addr_q;

endmodule
